// File: rtl/mem_access_stage.sv
// Data-memory access stage: a zeroing sweep on reset, then single-cycle word/byte accesses.
// Reads are registered and sign/zero-extended. Accepted accesses are mirrored onto the export ports.
module mem_access_stage #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 11,
   parameter int DEPTH  = 2**ADDR_W,
   parameter int OUT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              ctr_datamem_MR,
   input  logic              ctr_datamem_MW,
   input  logic              ctr_byte,
   input  logic              ctr_sext,
   input  logic [ADDR_W-1:0] datamem_address,
   input  logic [DATA_W-1:0] datamem_data,
   output logic [OUT_W-1:0]  data_out,
   output logic              out_valid,
   output logic              busy,
   output logic              err_oob,
   output logic [ADDR_W-1:0] datamem_export_address,
   output logic [DATA_W-1:0] datamem_export_data,
   output logic              datamem_export_MR,
   output logic              datamem_export_MW
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {ST_INIT, ST_READY} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  init_cnt_q, init_cnt_d;
   logic [OUT_W-1:0]  data_out_q, data_out_d;
   logic              out_valid_q, out_valid_d;
   logic              err_oob_q, err_oob_d;
   logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
   logic [DATA_W-1:0] exp_data_q, exp_data_d;
   logic              exp_mr_q, exp_mr_d;
   logic              exp_mw_q, exp_mw_d;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              accept;
   logic              in_range;
   logic [IDX_W-1:0]  mem_idx;
   logic [DATA_W-1:0] rd_word;
   logic [OUT_W-1:0]  rd_ext;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   assign accept   = !reset && (state_q == ST_READY) && enable && (ctr_datamem_MR || ctr_datamem_MW);
   assign in_range = (int'(datamem_address) < DEPTH);
   assign mem_idx  = datamem_address[IDX_W-1:0];
   // Combinational read of the current contents gives read-before-write for MR+MW.
   assign rd_word  = mem[mem_idx];

   always_comb begin
      rd_ext = '0;
      if (ctr_byte) begin
         if (ctr_sext) rd_ext = {OUT_W{rd_word[7]}};
         rd_ext[7:0] = rd_word[7:0];
      end else begin
         if (ctr_sext) rd_ext = {OUT_W{rd_word[DATA_W-1]}};
         rd_ext[DATA_W-1:0] = rd_word;
      end
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = init_cnt_q;
      mem_wdata = '0;
      if (!reset) begin
         if (state_q == ST_INIT) begin
            mem_we = 1'b1;
         end else if (accept && ctr_datamem_MW && in_range) begin
            mem_we    = 1'b1;
            mem_waddr = mem_idx;
            mem_wdata = ctr_byte ? {rd_word[DATA_W-1:8], datamem_data[7:0]} : datamem_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      data_out_d  = data_out_q;
      out_valid_d = 1'b0;
      err_oob_d   = 1'b0;
      exp_addr_d  = exp_addr_q;
      exp_data_d  = exp_data_q;
      exp_mr_d    = exp_mr_q;
      exp_mw_d    = exp_mw_q;
      if (state_q == ST_INIT) begin
         init_cnt_d = init_cnt_q + 1'b1;
         if (init_cnt_q == IDX_W'(DEPTH - 1)) begin
            state_d    = ST_READY;
            init_cnt_d = '0;
         end
      end
      if (accept) begin
         err_oob_d  = !in_range;
         exp_addr_d = datamem_address;
         exp_data_d = datamem_data;
         exp_mr_d   = ctr_datamem_MR;
         exp_mw_d   = ctr_datamem_MW;
         if (ctr_datamem_MR) begin
            out_valid_d = 1'b1;
            data_out_d  = in_range ? rd_ext : '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_INIT;
         init_cnt_q  <= '0;
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
         err_oob_q   <= 1'b0;
         exp_addr_q  <= '0;
         exp_data_q  <= '0;
         exp_mr_q    <= 1'b0;
         exp_mw_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
         err_oob_q   <= err_oob_d;
         exp_addr_q  <= exp_addr_d;
         exp_data_q  <= exp_data_d;
         exp_mr_q    <= exp_mr_d;
         exp_mw_q    <= exp_mw_d;
      end
   end

   assign busy                   = (state_q == ST_INIT);
   assign data_out               = data_out_q;
   assign out_valid              = out_valid_q;
   assign err_oob                = err_oob_q;
   assign datamem_export_address = exp_addr_q;
   assign datamem_export_data    = exp_data_q;
   assign datamem_export_MR      = exp_mr_q;
   assign datamem_export_MW      = exp_mw_q;

endmodule
